// File: rtl/washer_pkg.sv
// Shared types and helpers for the parametrised washer controller.
// Optional prewash support is compiled in with WASHER_PREWASH_EN.
package washer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
`ifdef WASHER_PREWASH_EN
    ST_PREWASH = 4'd1,
`endif
    ST_FILL    = 4'd2,
    ST_WASH    = 4'd3,
    ST_DRAIN   = 4'd4,
    ST_RFILL   = 4'd5,
    ST_RINSE   = 4'd6,
    ST_RDRAIN  = 4'd7,
    ST_SPIN    = 4'd8,
    ST_DONE    = 4'd9
  } state_e;

  localparam logic [2:0] PROG_COLD      = 3'b000;
  localparam logic [2:0] PROG_HOT       = 3'b001;
  localparam logic [2:0] PROG_RINSE_DRY = 3'b010;
  localparam logic [2:0] PROG_DRY       = 3'b011;
  localparam logic [2:0] PROG_PRE_COLD  = 3'b100;
  localparam logic [2:0] PROG_PRE_HOT   = 3'b101;

  localparam logic [1:0] MOTOR_OFF   = 2'b00;
  localparam logic [1:0] MOTOR_WASH  = 2'b01;
  localparam logic [1:0] MOTOR_RINSE = 2'b10;
  localparam logic [1:0] MOTOR_SPIN  = 2'b11;

  // Total ticks a program will run; prewash codes add one extra fill-length phase.
  function automatic int unsigned program_total(
    input logic [2:0]  prog,
    input int unsigned fill_t,
    input int unsigned wash_t,
    input int unsigned drain_t,
    input int unsigned rinse_t,
    input int unsigned spin_t,
    input int unsigned num_rinse
  );
    int unsigned rinse_part;
    int unsigned total;
    rinse_part = num_rinse * (fill_t + rinse_t + drain_t);
    case (prog)
      PROG_COLD, PROG_HOT:         total = fill_t + wash_t + drain_t + rinse_part + spin_t;
      PROG_RINSE_DRY:              total = rinse_part + spin_t;
      PROG_DRY:                    total = spin_t;
      PROG_PRE_COLD, PROG_PRE_HOT: total = 32'd2 * fill_t + wash_t + drain_t + rinse_part + spin_t;
      default:                     total = 32'd0;
    endcase
    return total;
  endfunction

endpackage

// File: rtl/washer_tick_gen.sv
// Timer-tick prescaler: counts enabled cycles and pulses tick on every TICK_DIV-th one.
module washer_tick_gen #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 32'd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  assign tick = en && (cnt_r == CNT_MAX);

  // Prescaler counter; frozen when not enabled, wraps to zero on tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= CNT_ZERO;
    end else if (clr) begin
      cnt_r <= CNT_ZERO;
    end else if (en) begin
      cnt_r <= tick ? CNT_ZERO : (cnt_r + CNT_ONE);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/washer_ctrl_param.sv
// Washing-machine phase sequencer with soap interlock, power hold and door lock.
// Prewash programs (codes 100/101) exist only when WASHER_PREWASH_EN is defined.
module washer_ctrl_param
  import washer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 10,
  parameter int unsigned FILL_T    = 3,
  parameter int unsigned WASH_T    = 5,
  parameter int unsigned DRAIN_T   = 2,
  parameter int unsigned RINSE_T   = 3,
  parameter int unsigned SPIN_T    = 4,
  parameter int unsigned NUM_RINSE = 1,
  parameter int unsigned TIMER_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power,
  input  logic [2:0]         program_selection,
  input  logic               start,
  input  logic               doorclosed,
  input  logic               soap,
  output logic               valve_in_cold,
  output logic               valve_in_hot,
  output logic               valve_out,
  output logic [1:0]         motor,
  output logic [TIMER_W-1:0] timer_display,
  output logic               program_done,
  output logic               soap_warning,
  output logic               soap_in,
  output logic               lockDoor
);

  localparam logic [TIMER_W-1:0] T_ZERO    = TIMER_W'(0);
  localparam logic [TIMER_W-1:0] T_ONE     = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] FILL_LEN  = TIMER_W'(FILL_T);
  localparam logic [TIMER_W-1:0] WASH_LEN  = TIMER_W'(WASH_T);
  localparam logic [TIMER_W-1:0] DRAIN_LEN = TIMER_W'(DRAIN_T);
  localparam logic [TIMER_W-1:0] RINSE_LEN = TIMER_W'(RINSE_T);
  localparam logic [TIMER_W-1:0] SPIN_LEN  = TIMER_W'(SPIN_T);
  localparam logic [1:0]         RINSE_LAST = 2'(NUM_RINSE - 32'd1);

  state_e             state_r, state_nx_s, first_state_s;
  logic [2:0]         prog_r, prog_nx_s;
  logic               soap_ok_r, soap_ok_nx_s;
  logic [1:0]         rinse_cnt_r, rinse_cnt_nx_s;
  logic [TIMER_W-1:0] phase_cnt_r, phase_cnt_nx_s;
  logic [TIMER_W-1:0] timer_r, timer_nx_s;
  logic [TIMER_W-1:0] phase_len_s;
  logic               valid_prog_s, accept_s, active_s, en_s, tick_s, phase_end_s;
  logic               cold_nx_s, hot_nx_s, out_nx_s, done_nx_s, warn_nx_s;
  logic               soap_in_nx_s, lock_nx_s, hot_prog_s, hold_nx_s;
  logic [1:0]         motor_nx_s;

  washer_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en_s),
    .clr  (accept_s),
    .tick (tick_s)
  );

  // Program code validity and the phase each program starts in.
  always_comb begin
    valid_prog_s  = 1'b0;
    first_state_s = ST_IDLE;
    case (program_selection)
      PROG_COLD, PROG_HOT: begin
        valid_prog_s  = 1'b1;
        first_state_s = ST_FILL;
      end
      PROG_RINSE_DRY: begin
        valid_prog_s  = 1'b1;
        first_state_s = ST_RFILL;
      end
      PROG_DRY: begin
        valid_prog_s  = 1'b1;
        first_state_s = ST_SPIN;
      end
`ifdef WASHER_PREWASH_EN
      PROG_PRE_COLD, PROG_PRE_HOT: begin
        valid_prog_s  = 1'b1;
        first_state_s = ST_PREWASH;
      end
`endif
      default: begin
        valid_prog_s  = 1'b0;
        first_state_s = ST_IDLE;
      end
    endcase
  end

  // Tick length of the phase currently running.
  always_comb begin
    phase_len_s = T_ONE;
    case (state_r)
`ifdef WASHER_PREWASH_EN
      ST_PREWASH:         phase_len_s = FILL_LEN;
`endif
      ST_FILL, ST_RFILL:  phase_len_s = FILL_LEN;
      ST_WASH:            phase_len_s = WASH_LEN;
      ST_DRAIN, ST_RDRAIN: phase_len_s = DRAIN_LEN;
      ST_RINSE:           phase_len_s = RINSE_LEN;
      ST_SPIN:            phase_len_s = SPIN_LEN;
      default:            phase_len_s = T_ONE;
    endcase
  end

  assign active_s    = (state_r != ST_IDLE) && (state_r != ST_DONE);
  // A FILL waiting for soap is a frozen cycle, just like a power hold.
  assign en_s        = active_s && power && !((state_r == ST_FILL) && !soap_ok_r);
  assign phase_end_s = tick_s && (phase_cnt_r == (phase_len_s - T_ONE));
  assign accept_s    = !active_s && start && power && doorclosed && valid_prog_s;

  // Next-state: start acceptance, soap latch, tick accounting and phase sequencing.
  always_comb begin
    state_nx_s     = state_r;
    prog_nx_s      = prog_r;
    soap_ok_nx_s   = soap_ok_r;
    rinse_cnt_nx_s = rinse_cnt_r;
    phase_cnt_nx_s = phase_cnt_r;
    timer_nx_s     = timer_r;
    if (accept_s) begin
      state_nx_s     = first_state_s;
      prog_nx_s      = program_selection;
      soap_ok_nx_s   = soap;
      rinse_cnt_nx_s = 2'd0;
      phase_cnt_nx_s = T_ZERO;
      timer_nx_s     = TIMER_W'(program_total(program_selection, FILL_T, WASH_T, DRAIN_T,
                                              RINSE_T, SPIN_T, NUM_RINSE));
    end else begin
      soap_ok_nx_s = soap_ok_r | ((state_r == ST_FILL) & soap);
      if (tick_s) begin
        timer_nx_s = (timer_r == T_ZERO) ? T_ZERO : (timer_r - T_ONE);
        if (phase_end_s) begin
          phase_cnt_nx_s = T_ZERO;
          case (state_r)
`ifdef WASHER_PREWASH_EN
            ST_PREWASH: state_nx_s = ST_FILL;
`endif
            ST_FILL:    state_nx_s = ST_WASH;
            ST_WASH:    state_nx_s = ST_DRAIN;
            ST_DRAIN:   state_nx_s = ST_RFILL;
            ST_RFILL:   state_nx_s = ST_RINSE;
            ST_RINSE:   state_nx_s = ST_RDRAIN;
            ST_RDRAIN: begin
              if (rinse_cnt_r == RINSE_LAST) begin
                state_nx_s     = ST_SPIN;
                rinse_cnt_nx_s = 2'd0;
              end else begin
                state_nx_s     = ST_RFILL;
                rinse_cnt_nx_s = rinse_cnt_r + 2'd1;
              end
            end
            ST_SPIN:    state_nx_s = ST_DONE;
            default:    state_nx_s = ST_IDLE;
          endcase
        end else begin
          phase_cnt_nx_s = phase_cnt_r + T_ONE;
        end
      end else begin
        phase_cnt_nx_s = phase_cnt_r;
      end
    end
  end

  assign hot_prog_s = (prog_nx_s == PROG_HOT) || (prog_nx_s == PROG_PRE_HOT);

  // Output decode from the state being entered, so outputs can be registered.
  always_comb begin
    cold_nx_s    = 1'b0;
    hot_nx_s     = 1'b0;
    out_nx_s     = 1'b0;
    motor_nx_s   = MOTOR_OFF;
    done_nx_s    = 1'b0;
    warn_nx_s    = 1'b0;
    soap_in_nx_s = 1'b0;
    lock_nx_s    = 1'b1;
    case (state_nx_s)
      ST_IDLE: lock_nx_s = 1'b0;
`ifdef WASHER_PREWASH_EN
      ST_PREWASH: begin
        cold_nx_s  = 1'b1;
        motor_nx_s = MOTOR_WASH;
      end
`endif
      ST_FILL: begin
        if (soap_ok_nx_s) begin
          soap_in_nx_s = 1'b1;
          hot_nx_s     = hot_prog_s;
          cold_nx_s    = !hot_prog_s;
        end else begin
          warn_nx_s = 1'b1;
        end
      end
      ST_WASH:             motor_nx_s = MOTOR_WASH;
      ST_DRAIN, ST_RDRAIN: out_nx_s   = 1'b1;
      ST_RFILL:            cold_nx_s  = 1'b1;
      ST_RINSE:            motor_nx_s = MOTOR_RINSE;
      ST_SPIN: begin
        motor_nx_s = MOTOR_SPIN;
        out_nx_s   = 1'b1;
      end
      ST_DONE: begin
        done_nx_s = 1'b1;
        lock_nx_s = 1'b0;
      end
      default: lock_nx_s = 1'b0;
    endcase
  end

  assign hold_nx_s     = lock_nx_s && !power;
  assign timer_display = timer_r;

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      prog_r        <= PROG_COLD;
      soap_ok_r     <= 1'b0;
      rinse_cnt_r   <= 2'd0;
      phase_cnt_r   <= T_ZERO;
      timer_r       <= T_ZERO;
      valve_in_cold <= 1'b0;
      valve_in_hot  <= 1'b0;
      valve_out     <= 1'b0;
      motor         <= MOTOR_OFF;
      program_done  <= 1'b0;
      soap_warning  <= 1'b0;
      soap_in       <= 1'b0;
      lockDoor      <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      prog_r        <= prog_nx_s;
      soap_ok_r     <= soap_ok_nx_s;
      rinse_cnt_r   <= rinse_cnt_nx_s;
      phase_cnt_r   <= phase_cnt_nx_s;
      timer_r       <= timer_nx_s;
      valve_in_cold <= cold_nx_s & ~hold_nx_s;
      valve_in_hot  <= hot_nx_s & ~hold_nx_s;
      valve_out     <= out_nx_s & ~hold_nx_s;
      motor         <= hold_nx_s ? MOTOR_OFF : motor_nx_s;
      program_done  <= done_nx_s;
      soap_warning  <= warn_nx_s;
      soap_in       <= soap_in_nx_s;
      lockDoor      <= lock_nx_s;
    end
  end

endmodule
